// File: rtl/do_shift.sv
// -----------------------------------------------------------------------------
// do_shift
// Registered, single-cycle barrel shifter. It gives exact Verilog shift
// semantics for a full-width shift amount. The amount is never truncated, and
// any amount >= DATA_W drains the word: it becomes zero, or all sign bits for
// an arithmetic right shift.
//
// Parameters
//   DATA_W      data/result width, 1..64
//   AMT_W       shift-amount width, 1..32
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    request strobe; operands are captured when high
//   in_data     operand word
//   in_amt      unsigned shift amount; all bits are significant
//   in_op       00 lsl, 01 asl (same as lsl), 10 lsr, 11 asr
//   out_valid   result strobe, one cycle after the request
//   out_data    shifted result; holds its value while no request arrives
//   out_drained high when the captured amount was >= DATA_W
// -----------------------------------------------------------------------------
module do_shift #(
    parameter int DATA_W = 7,
    parameter int AMT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_drained
);

    // Number of barrel stages. A 1-bit word still gets one stage so that the
    // slices below stay legal.
    localparam int SHW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASL = 2'b01;
    localparam logic [1:0] OP_LSR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    localparam logic [32:0] DATA_W_C = 33'(DATA_W);

    logic [32:0]       amt_ext_s;
    logic [SHW-1:0]    amt_low_s;
    logic              upper_any_s;
    logic              low_ge_s;
    logic              drained_s;
    logic              sign_s;
    logic [DATA_W-1:0] barrel_s;
    logic [DATA_W-1:0] result_s;

    // Amount decode. If any bit at or above SHW is set, the amount is at least
    // 2**SHW, which is already >= DATA_W. Otherwise only the low bits need to
    // be compared against DATA_W.
    always_comb begin
        amt_ext_s   = 33'(in_amt);
        amt_low_s   = amt_ext_s[SHW-1:0];
        upper_any_s = |amt_ext_s[32:SHW];
        low_ge_s    = (33'(amt_low_s) >= DATA_W_C);
        drained_s   = upper_any_s | low_ge_s;
        sign_s      = in_data[DATA_W-1];
    end

    // Log-depth mux barrel on the low amount bits. Each stage shifts by a
    // constant 2**i. For an arithmetic right shift, the vacated MSBs are
    // filled with the sign bit through a mask.
    always_comb begin
        barrel_s = in_data;
        for (int i = 0; i < SHW; i++) begin
            if (amt_low_s[i]) begin
                case (in_op)
                    OP_LSL, OP_ASL: barrel_s = barrel_s << (1 << i);
                    OP_LSR:         barrel_s = barrel_s >> (1 << i);
                    OP_ASR:         barrel_s = (barrel_s >> (1 << i)) |
                                               ({DATA_W{sign_s}} &
                                                ~({DATA_W{1'b1}} >> (1 << i)));
                    default:        barrel_s = barrel_s;
                endcase
            end else begin
                barrel_s = barrel_s;
            end
        end
    end

    // Drained override. The barrel result is only meaningful when the amount
    // is below DATA_W.
    always_comb begin
        if (drained_s) begin
            if (in_op == OP_ASR) begin
                result_s = {DATA_W{sign_s}};
            end else begin
                result_s = {DATA_W{1'b0}};
            end
        end else begin
            result_s = barrel_s;
        end
    end

    // Output register. Reset wins over a request on the same edge. Data and the
    // drained flag hold their values across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= {DATA_W{1'b0}};
            out_drained <= 1'b0;
        end else if (in_valid) begin
            out_valid   <= 1'b1;
            out_data    <= result_s;
            out_drained <= drained_s;
        end else begin
            out_valid   <= 1'b0;
            out_data    <= out_data;
            out_drained <= out_drained;
        end
    end

endmodule

// File: tb/tb_do_shift.sv
// -----------------------------------------------------------------------------
// tb_do_shift
// Directed, self-checking bench for do_shift at its default widths
// (DATA_W=7, AMT_W=32). Each step drives a request on the falling edge. It
// then samples the registered outputs 1 time unit after the next rising edge
// and compares them against hand-computed values.
// -----------------------------------------------------------------------------
module tb_do_shift;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [6:0]  in_data;
    logic [31:0] in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic [6:0]  out_data;
    logic        out_drained;

    int checks;
    int failures;

    do_shift #(.DATA_W(7), .AMT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_drained(out_drained)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then wait until just after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [6:0] d,
                        input logic [31:0] a, input logic [1:0] op);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs against the expected values.
    task automatic expect_out(input string tag, input logic ev,
                              input logic [6:0] ed, input logic edr);
        checks++;
        assert (out_valid === ev) else begin
            failures++;
            $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, ev);
        end
        checks++;
        assert (out_data === ed) else begin
            failures++;
            $error("FAIL %s out_data observed=%0d expected=%0d", tag, out_data, ed);
        end
        checks++;
        assert (out_drained === edr) else begin
            failures++;
            $error("FAIL %s out_drained observed=%0b expected=%0b", tag, out_drained, edr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd54;
        in_amt   = 32'd1;
        in_op    = 2'b00;

        // Reset held for two edges while a request is presented
        step(1'b1, 1'b1, 7'd54, 32'd1, 2'b00);
        expect_out("reset0", 1'b0, 7'd0, 1'b0);
        step(1'b1, 1'b1, 7'd127, 32'd3, 2'b10);
        expect_out("reset1", 1'b0, 7'd0, 1'b0);

        // Back-to-back stream of directed vectors
        step(1'b0, 1'b1, 7'd54, 32'hFFFF_FFFF, 2'b00);
        expect_out("lsl_huge", 1'b1, 7'd0, 1'b1);
        step(1'b0, 1'b1, 7'd54, 32'hFFFF_FFFF, 2'b01);
        expect_out("asl_huge", 1'b1, 7'd0, 1'b1);
        step(1'b0, 1'b1, 7'd54, 32'd1, 2'b00);
        expect_out("lsl_1", 1'b1, 7'd108, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd2, 2'b01);
        expect_out("asl_2", 1'b1, 7'd88, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd6, 2'b00);
        expect_out("lsl_6", 1'b1, 7'd0, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd7, 2'b00);
        expect_out("lsl_7", 1'b1, 7'd0, 1'b1);
        step(1'b0, 1'b1, 7'd127, 32'd3, 2'b10);
        expect_out("lsr_3", 1'b1, 7'd15, 1'b0);
        step(1'b0, 1'b1, 7'd64, 32'hFFFF_FFFF, 2'b11);
        expect_out("asr_huge", 1'b1, 7'd127, 1'b1);
        step(1'b0, 1'b1, 7'd64, 32'd2, 2'b11);
        expect_out("asr_2", 1'b1, 7'd112, 1'b0);
        step(1'b0, 1'b1, 7'd64, 32'h0000_0100, 2'b10);
        expect_out("lsr_256", 1'b1, 7'd0, 1'b1);
        step(1'b0, 1'b1, 7'd54, 32'd7, 2'b11);
        expect_out("asr_7_pos", 1'b1, 7'd0, 1'b1);
        step(1'b0, 1'b1, 7'd101, 32'd6, 2'b11);
        expect_out("asr_6_neg", 1'b1, 7'd127, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd5, 2'b10);
        expect_out("lsr_5", 1'b1, 7'd1, 1'b0);

        // Pass-through for every op
        step(1'b0, 1'b1, 7'd54, 32'd0, 2'b00);
        expect_out("pass_00", 1'b1, 7'd54, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd0, 2'b01);
        expect_out("pass_01", 1'b1, 7'd54, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd0, 2'b10);
        expect_out("pass_10", 1'b1, 7'd54, 1'b0);
        step(1'b0, 1'b1, 7'd54, 32'd0, 2'b11);
        expect_out("pass_11", 1'b1, 7'd54, 1'b0);

        // One idle cycle: the strobe drops and data/drained hold
        step(1'b0, 1'b1, 7'd64, 32'd9, 2'b11);
        expect_out("pre_idle", 1'b1, 7'd127, 1'b1);
        step(1'b0, 1'b0, 7'd3, 32'd1, 2'b00);
        expect_out("idle_hold", 1'b0, 7'd127, 1'b1);
        step(1'b0, 1'b1, 7'd3, 32'd1, 2'b00);
        expect_out("post_idle", 1'b1, 7'd6, 1'b0);

        // Reset mid-stream discards the concurrent request
        step(1'b0, 1'b1, 7'd127, 32'd1, 2'b10);
        expect_out("pre_rst", 1'b1, 7'd63, 1'b0);
        step(1'b1, 1'b1, 7'd64, 32'hFFFF_FFFF, 2'b11);
        expect_out("mid_rst", 1'b0, 7'd0, 1'b0);
        step(1'b0, 1'b1, 7'd1, 32'd6, 2'b00);
        expect_out("after_rst", 1'b1, 7'd64, 1'b0);
        step(1'b0, 1'b0, 7'd0, 32'd0, 2'b00);
        expect_out("final_idle", 1'b0, 7'd64, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/do_shift.md
# do_shift

Registered, single-cycle barrel shifter. It takes a data word and a full 32-bit shift amount, and applies one of four shift operations with exact Verilog shift semantics: the amount is never truncated, and shifting by the data width or more drains the word completely. It sits in the datapath as the reference shift stage for constant-folding and large-amount corner cases, e.g. left-shifting 54 (octal 66) by 0xFFFF_FFFF must yield 0.

## Interface
- DATA_W, default 7: data and result width in bits; legal range 1..64.
- AMT_W, default 32: shift-amount width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe; operands are sampled on every clk edge where in_valid=1.
- in_data  input  DATA_W  operand; narrower sources are zero-extended by the producer.
- in_amt  input  AMT_W  unsigned shift amount; all bits are significant.
- in_op  input  2  00 logical left, 01 arithmetic left, 10 logical right, 11 arithmetic right.
- out_valid  output  1  result strobe.
- out_data  output  DATA_W  shifted result.
- out_drained  output  1  high when in_amt >= DATA_W for the captured request.

## Operation
- Logical left (00) and arithmetic left (01) are identical: out = (in_data << in_amt) truncated to DATA_W bits, with zeros filled from the LSB.
- Logical right (10): zeros are filled from the MSB.
- Arithmetic right (11): the result is filled with in_data[DATA_W-1].
- in_amt is compared at its full AMT_W width. It is never reduced modulo DATA_W and never reduced to log2(DATA_W) bits.
- When in_amt >= DATA_W (drained case):
  - ops 00, 01 and 10 produce all zeros;
  - op 11 produces DATA_W copies of the sign bit.
- in_amt = 0 passes in_data through unchanged for every op.
- out_drained = (in_amt >= DATA_W), independent of in_op.
- Implementation: a log-depth mux barrel using the low ceil(log2(DATA_W)) amount bits, plus an OR-reduce of the upper amount bits and a compare against DATA_W that forces the drained result.
- The implementation must not depend on the simulator's handling of shifts by huge amounts.

## Timing
- Latency is 1 cycle. A request accepted at edge N appears on out_data/out_drained, with out_valid=1, after edge N.
- Throughput is one request per cycle; there is no backpressure.
- Cycles with in_valid=0:
  - out_valid goes 0 after the next edge;
  - out_data and out_drained hold their last values.
- Reset values are out_valid=0, out_data=0, out_drained=0.
- rst overrides in_valid on the same edge. A request presented during a reset edge is discarded.
- Reset applied mid-stream clears the pipeline with no residual output.
- Back-to-back requests with different ops and amounts do not interfere with each other.

## Test plan
- Reset: hold rst=1 for 2 edges with in_valid=1 -> out_valid=0, out_data=0, out_drained=0.
- Huge left shift: in_data=7'd54 (6'o66 zero-extended), in_amt=32'hFFFF_FFFF, ops 00 and 01 -> out_data=0, out_drained=1, one cycle later.
- Small left shifts on in_data=54:
  - amt 1 -> 108;
  - amt 2 -> 88;
  - amt 6 -> 0 with out_drained=0;
  - amt 7 -> 0 with out_drained=1.
- Right shifts:
  - op 10, in_data=127, amt 3 -> 15;
  - op 11, in_data=64, amt 32'hFFFF_FFFF -> 127;
  - op 11, in_data=64, amt 2 -> 112;
  - op 10, in_data=64, amt 32'h0000_0100 -> 0.
- Pass-through: in_amt=0 with every op and in_data=54 -> out_data=54, out_drained=0.
- Pipeline behaviour:
  - back-to-back streaming of all the vectors above matches per cycle;
  - deasserting in_valid for one cycle gives out_valid=0 while out_data holds;
  - asserting rst mid-stream gives out_valid=0 on the next cycle.
